mem2_load_queue: RTL and testbench

- Parametrised successor to the single-entry memory stage 2.
- Holds up to DEPTH in-order memory-stage instructions while their DCache load responses are outstanding.
- Aligns and sign- or zero-extends load data, and presents results to writeback in order through a valid/ready handshake.
- Forwards the youngest entry's result to dispatch; after a flush, drops late DCache responses that belong to squashed loads.

---
 rtl/core_types.sv | 26 ++
 rtl/mem2_load_queue_chk.sv | 15 +
 rtl/mem2_load_queue_load_align.sv | 58 +++++
 rtl/mem2_load_queue.sv | 205 ++++++++++++++++++++
 tb/tb_mem2_load_queue.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/core_types.sv
// Shared core types: load kinds and the memory-stage-2 load queue entry.
package core_types;

  localparam int CORE_DATA_WIDTH     = 32;
  localparam int CORE_REG_ADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4,
    LL    = 3'd5
  } ld_op_t;

  // One in-flight memory-stage instruction; done=1 once wdata is final.
  typedef struct packed {
    logic                           wreg;
    logic [CORE_REG_ADDR_WIDTH-1:0] waddr;
    logic [CORE_DATA_WIDTH-1:0]     wdata;
    ld_op_t                         ldop;
    logic [1:0]                     addr_lo;
    logic                           done;
  } mem2_lq_entry_t;

endpackage

// File: rtl/mem2_load_queue_chk.sv
// Protocol checker for mem2_load_queue (instantiated only when SIMU is defined).
module mem2_load_queue_chk (
  input logic clk,
  input logic rst,
  input logic proto_err,
  input logic orph_ovf
);

  // A DCache response must always have a waiting entry or an orphan to absorb it.
  a_no_stray_resp: assert property (@(posedge clk) disable iff (rst) !proto_err);

  // The orphan counter must never need to saturate.
  a_no_orph_ovf: assert property (@(posedge clk) disable iff (rst) !orph_ovf);

endmodule

// File: rtl/mem2_load_queue_load_align.sv
// load_align: combinational byte/half/word extraction with sign or zero
// extension. Shared with the uncached load path.
module load_align
  import core_types::*;
#(
  parameter int DATA_WIDTH = CORE_DATA_WIDTH
) (
  input  ld_op_t                ldop,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] word,
  output logic [DATA_WIDTH-1:0] result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte/half, then extend according to the load kind.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    result = {DATA_WIDTH{1'b0}};
    case (addr_lo)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr_lo[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (ldop)
      LD_B:  result = {{(DATA_WIDTH-8){byte_s[7]}}, byte_s};
      LD_BU: result = {{(DATA_WIDTH-8){1'b0}}, byte_s};
      LD_H: begin
        // Misaligned halfword reads return zero.
        if (addr_lo[0]) begin
          result = {DATA_WIDTH{1'b0}};
        end else begin
          result = {{(DATA_WIDTH-16){half_s[15]}}, half_s};
        end
      end
      LD_HU: begin
        if (addr_lo[0]) begin
          result = {DATA_WIDTH{1'b0}};
        end else begin
          result = {{(DATA_WIDTH-16){1'b0}}, half_s};
        end
      end
      LD_W:    result = word;
      LL:      result = word;
      default: result = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/mem2_load_queue.sv
// mem2_load_queue: in-order queue of memory-stage-2 instructions awaiting
// DCache load responses. Optional macros:
//   MEM2_LOAD_BYPASS_EN - a response aimed at the head is presented to
//                         writeback in the same cycle.
//   SIMU                - binds the protocol checker.
module mem2_load_queue
  import core_types::*;
#(
  parameter int DEPTH          = 4,
  parameter int DATA_WIDTH     = CORE_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = CORE_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_wreg,
  input  logic [REG_ADDR_WIDTH-1:0] in_waddr,
  input  logic [DATA_WIDTH-1:0]     in_wdata,
  input  logic                      in_load,
  input  logic                      in_excp,
  input  logic [2:0]                in_ldop,
  input  logic [1:0]                in_addr_lo,
  input  logic                      data_ok,
  input  logic [DATA_WIDTH-1:0]     cache_data_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_wreg,
  output logic [REG_ADDR_WIDTH-1:0] out_waddr,
  output logic [DATA_WIDTH-1:0]     out_wdata,
  output logic                      fwd_wreg,
  output logic                      fwd_valid,
  output logic [REG_ADDR_WIDTH-1:0] fwd_waddr,
  output logic [DATA_WIDTH-1:0]     fwd_wdata
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int ORPH_W = $clog2(DEPTH + 1) + 1;
  localparam int OW1    = ORPH_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [OW1-1:0]   ORPH_MAX_C = {1'b0, {ORPH_W{1'b1}}};
  localparam mem2_lq_entry_t   ENTRY_ZERO_C = mem2_lq_entry_t'({$bits(mem2_lq_entry_t){1'b0}});

  mem2_lq_entry_t    entries_r [DEPTH];
  logic [PTR_W-1:0]  head_r, tail_r;
  logic [CNT_W-1:0]  count_r;
  logic [ORPH_W-1:0] orphans_r;

  logic              empty_s, enq_s, deq_s, bypass_s;
  logic              waiting_s, steer_s, orph_hit_s, fwd_hit_s, orph_ovf_s;
  logic [PTR_W-1:0]  resp_ptr_s, scan_idx_s, young_idx_s;
  logic [CNT_W-1:0]  pend_cnt_s, pend_after_s;
  logic [OW1-1:0]    orph_base_s, orph_sum_s;
  logic [ORPH_W-1:0] orphans_nxt_s;
  logic [DATA_WIDTH-1:0] align_data_s;
  mem2_lq_entry_t    new_entry_s;

  assign empty_s     = (count_r == {CNT_W{1'b0}});
  assign in_ready    = (count_r < DEPTH_C);
  assign enq_s       = in_valid && in_ready;
  assign deq_s       = out_valid && out_ready;
  assign young_idx_s = tail_r - PTR_W'(1);

  // Find the oldest entry still waiting for a response (resp_ptr) and count all waiting entries.
  always_comb begin
    waiting_s  = 1'b0;
    resp_ptr_s = head_r;
    pend_cnt_s = {CNT_W{1'b0}};
    scan_idx_s = head_r;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx_s = head_r + PTR_W'(i);
      if ((CNT_W'(i) < count_r) && !entries_r[scan_idx_s].done) begin
        pend_cnt_s = pend_cnt_s + CNT_W'(1);
        if (!waiting_s) begin
          waiting_s  = 1'b1;
          resp_ptr_s = scan_idx_s;
        end else begin
          waiting_s  = waiting_s;
        end
      end else begin
        pend_cnt_s = pend_cnt_s;
      end
    end
  end

  // Orphans absorb responses first; otherwise a response completes the oldest waiting load.
  assign orph_hit_s = data_ok && (orphans_r != {ORPH_W{1'b0}});
  assign steer_s    = data_ok && (orphans_r == {ORPH_W{1'b0}}) && waiting_s;
  assign fwd_hit_s  = steer_s && (resp_ptr_s == young_idx_s);

  load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .ldop    (entries_r[resp_ptr_s].ldop),
    .addr_lo (entries_r[resp_ptr_s].addr_lo),
    .word    (cache_data_i),
    .result  (align_data_s)
  );

`ifdef MEM2_LOAD_BYPASS_EN
  assign bypass_s = steer_s && (resp_ptr_s == head_r);
`else
  assign bypass_s = 1'b0;
`endif

  // Entry image written at enqueue: non-loads and faulting loads are final immediately.
  always_comb begin
    new_entry_s         = ENTRY_ZERO_C;
    new_entry_s.wreg    = in_wreg;
    new_entry_s.waddr   = in_waddr;
    new_entry_s.wdata   = in_wdata;
    new_entry_s.ldop    = ld_op_t'(in_ldop);
    new_entry_s.addr_lo = in_addr_lo;
    new_entry_s.done    = !in_load || in_excp;
  end

  // Writeback port: head entry when complete (or bypassed), zero otherwise.
  always_comb begin
    out_valid = !empty_s && (entries_r[head_r].done || bypass_s);
    out_wreg  = 1'b0;
    out_waddr = {REG_ADDR_WIDTH{1'b0}};
    out_wdata = {DATA_WIDTH{1'b0}};
    if (out_valid) begin
      out_wreg  = entries_r[head_r].wreg;
      out_waddr = entries_r[head_r].waddr;
      out_wdata = bypass_s ? align_data_s : entries_r[head_r].wdata;
    end else begin
      out_wreg  = 1'b0;
    end
  end

  // Forwarding port: youngest entry, finalised early when its response arrives this cycle.
  always_comb begin
    fwd_wreg  = 1'b0;
    fwd_valid = 1'b0;
    fwd_waddr = {REG_ADDR_WIDTH{1'b0}};
    fwd_wdata = {DATA_WIDTH{1'b0}};
    if (!empty_s) begin
      fwd_wreg  = entries_r[young_idx_s].wreg;
      fwd_valid = entries_r[young_idx_s].done || fwd_hit_s;
      fwd_waddr = entries_r[young_idx_s].waddr;
      fwd_wdata = fwd_hit_s ? align_data_s : entries_r[young_idx_s].wdata;
    end else begin
      fwd_valid = 1'b0;
    end
  end

  // Orphan bookkeeping: on flush, every load still waiting after this cycle's steering becomes an orphan.
  always_comb begin
    pend_after_s  = pend_cnt_s - CNT_W'(steer_s);
    orph_base_s   = OW1'(orphans_r) - OW1'(orph_hit_s);
    orph_sum_s    = orph_base_s + OW1'(pend_after_s);
    orph_ovf_s    = flush && (orph_sum_s > ORPH_MAX_C);
    orphans_nxt_s = orph_base_s[ORPH_W-1:0];
    if (flush) begin
      orphans_nxt_s = orph_ovf_s ? ORPH_MAX_C[ORPH_W-1:0] : orph_sum_s[ORPH_W-1:0];
    end else begin
      orphans_nxt_s = orph_base_s[ORPH_W-1:0];
    end
  end

  // Queue state: reset, flush, or steer/enqueue/dequeue.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r    <= {PTR_W{1'b0}};
      tail_r    <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      orphans_r <= {ORPH_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        entries_r[i] <= ENTRY_ZERO_C;
      end
    end else if (flush) begin
      count_r   <= {CNT_W{1'b0}};
      head_r    <= tail_r;
      orphans_r <= orphans_nxt_s;
    end else begin
      orphans_r <= orphans_nxt_s;
      if (steer_s) begin
        entries_r[resp_ptr_s].wdata <= align_data_s;
        entries_r[resp_ptr_s].done  <= 1'b1;
      end
      if (enq_s) begin
        entries_r[tail_r] <= new_entry_s;
        tail_r            <= tail_r + PTR_W'(1);
      end
      if (deq_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(enq_s) - CNT_W'(deq_s);
    end
  end

`ifdef SIMU
  logic proto_err_s;
  assign proto_err_s = data_ok && (orphans_r == {ORPH_W{1'b0}}) && !waiting_s;

  mem2_load_queue_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .proto_err (proto_err_s),
    .orph_ovf  (orph_ovf_s)
  );
`endif

endmodule

// File: tb/tb_mem2_load_queue.sv
// Directed self-checking bench for mem2_load_queue (DEPTH=4, 32-bit data).
// Expectations adapt to MEM2_LOAD_BYPASS_EN when it is defined.
module tb_mem2_load_queue;

`ifdef MEM2_LOAD_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk, rst, flush;
  logic        in_valid, in_ready, in_wreg, in_load, in_excp;
  logic [4:0]  in_waddr;
  logic [31:0] in_wdata;
  logic [2:0]  in_ldop;
  logic [1:0]  in_addr_lo;
  logic        data_ok;
  logic [31:0] cache_data;
  logic        out_valid, out_ready, out_wreg;
  logic [4:0]  out_waddr;
  logic [31:0] out_wdata;
  logic        fwd_wreg, fwd_valid;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;

  int errors = 0;
  int checks = 0;

  mem2_load_queue dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_wreg      (in_wreg),
    .in_waddr     (in_waddr),
    .in_wdata     (in_wdata),
    .in_load      (in_load),
    .in_excp      (in_excp),
    .in_ldop      (in_ldop),
    .in_addr_lo   (in_addr_lo),
    .data_ok      (data_ok),
    .cache_data_i (cache_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_wreg     (out_wreg),
    .out_waddr    (out_waddr),
    .out_wdata    (out_wdata),
    .fwd_wreg     (fwd_wreg),
    .fwd_valid    (fwd_valid),
    .fwd_waddr    (fwd_waddr),
    .fwd_wdata    (fwd_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    flush = 1'b0; in_valid = 1'b0; in_wreg = 1'b0; in_waddr = 5'd0;
    in_wdata = 32'd0; in_load = 1'b0; in_excp = 1'b0; in_ldop = 3'd0;
    in_addr_lo = 2'd0; data_ok = 1'b0; cache_data = 32'd0; out_ready = 1'b0;
  endtask

  // Advance one cycle; inputs are re-driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    clr_in();
  endtask

  task automatic push(input logic [4:0] wa, input logic [2:0] op, input logic [1:0] al);
    in_valid = 1'b1; in_wreg = 1'b1; in_waddr = wa; in_load = 1'b1;
    in_excp = 1'b0; in_ldop = op; in_addr_lo = al; in_wdata = 32'hDEADBEEF;
  endtask

  // One load through an empty queue: enqueue, wait, respond, retire.
  task automatic load_case(input string tag, input logic [2:0] op, input logic [1:0] al,
                           input logic [31:0] resp, input logic [31:0] exp);
    step(); push(5'd5, op, al); #1;
    step(); #1;
    chk({tag, "_wait_ov"}, out_valid, 32'd0);
    chk({tag, "_wait_fv"}, fwd_valid, 32'd0);
    chk({tag, "_wait_fw"}, fwd_wreg, 32'd1);
    step(); data_ok = 1'b1; cache_data = resp; #1;
    chk({tag, "_resp_fv"}, fwd_valid, 32'd1);
    chk({tag, "_resp_fd"}, fwd_wdata, exp);
    chk({tag, "_resp_ov"}, out_valid, 32'(BYP));
    step(); out_ready = 1'b1; #1;
    chk({tag, "_out_v"}, out_valid, 32'd1);
    chk({tag, "_out_d"}, out_wdata, exp);
    chk({tag, "_out_a"}, out_waddr, 32'd5);
  endtask

  initial begin
    clr_in();
    rst = 1'b1;
    step(); step();
    rst = 1'b0; #1;
    chk("rst_ov", out_valid, 32'd0);
    chk("rst_ir", in_ready, 32'd1);
    chk("rst_od", out_wdata, 32'd0);
    chk("rst_fw", fwd_wreg, 32'd0);
    chk("rst_fv", fwd_valid, 32'd0);

    // Non-load: visible the cycle after enqueue, retires immediately.
    step(); in_valid = 1'b1; in_wreg = 1'b1; in_waddr = 5'd3; in_wdata = 32'h11; out_ready = 1'b1; #1;
    chk("nl_pre_ov", out_valid, 32'd0);
    step(); out_ready = 1'b1; #1;
    chk("nl_ov", out_valid, 32'd1);
    chk("nl_od", out_wdata, 32'h11);
    chk("nl_oa", out_waddr, 32'd3);
    chk("nl_ow", out_wreg, 32'd1);
    chk("nl_fv", fwd_valid, 32'd1);
    chk("nl_fd", fwd_wdata, 32'h11);
    chk("nl_fa", fwd_waddr, 32'd3);
    step(); #1;
    chk("nl_empty_ov", out_valid, 32'd0);
    chk("nl_empty_od", out_wdata, 32'd0);
    chk("nl_empty_fw", fwd_wreg, 32'd0);

    // Extraction cases.
    load_case("ldb",  3'd0, 2'd2, 32'h00F50000, 32'hFFFFFFF5);
    load_case("ldbu", 3'd3, 2'd2, 32'h00F50000, 32'h000000F5);
    load_case("ldh1", 3'd1, 2'd1, 32'h00F50000, 32'h00000000);
    load_case("ldh2", 3'd1, 2'd2, 32'h80010000, 32'hFFFF8001);
    load_case("ldhu", 3'd4, 2'd2, 32'h80010000, 32'h00008001);

    // Faulting load completes at enqueue with in_wdata.
    step(); push(5'd6, 3'd2, 2'd0); in_excp = 1'b1; in_wdata = 32'hE0E0; #1;
    step(); out_ready = 1'b1; #1;
    chk("excp_ov", out_valid, 32'd1);
    chk("excp_od", out_wdata, 32'hE0E0);

    // Fill to DEPTH, respond, drain in order, wrap the tail.
    for (int k = 0; k < 4; k++) begin
      step(); push(5'(k + 1), 3'd2, 2'd0); #1;
      chk("fill_ir", in_ready, 32'd1);
    end
    step(); #1;
    chk("full_ir", in_ready, 32'd0);
    chk("full_ov", out_valid, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step(); data_ok = 1'b1; cache_data = 32'(10 + k); #1;
    end
    step(); out_ready = 1'b1; #1;
    chk("drain0_ir", in_ready, 32'd0);
    chk("drain0_od", out_wdata, 32'hA);
    chk("drain0_oa", out_waddr, 32'd1);
    chk("drain0_fd", fwd_wdata, 32'hD);
    chk("drain0_fa", fwd_waddr, 32'd4);
    step(); out_ready = 1'b1; in_valid = 1'b1; in_wreg = 1'b1; in_waddr = 5'd7; in_wdata = 32'h77; #1;
    chk("drain1_ir", in_ready, 32'd1);
    chk("drain1_od", out_wdata, 32'hB);
    step(); out_ready = 1'b1; #1;
    chk("drain2_od", out_wdata, 32'hC);
    chk("wrap_fv", fwd_valid, 32'd1);
    chk("wrap_fd", fwd_wdata, 32'h77);
    chk("wrap_fa", fwd_waddr, 32'd7);
    step(); out_ready = 1'b1; #1;
    chk("drain3_od", out_wdata, 32'hD);
    step(); out_ready = 1'b1; #1;
    chk("wrap_od", out_wdata, 32'h77);
    chk("wrap_oa", out_waddr, 32'd7);

    // Flush with 3 pending loads: three later responses are orphans.
    for (int k = 0; k < 3; k++) begin
      step(); push(5'(8 + k), 3'd2, 2'd0); #1;
    end
    step(); flush = 1'b1; #1;
    step(); push(5'd12, 3'd2, 2'd0); #1;
    chk("fl_empty_ov", out_valid, 32'd0);
    chk("fl_empty_ir", in_ready, 32'd1);
    chk("fl_empty_fw", fwd_wreg, 32'd0);
    for (int k = 0; k < 3; k++) begin
      step(); data_ok = 1'b1; cache_data = 32'(k + 1); #1;
      chk("fl_orph_fv", fwd_valid, 32'd0);
      chk("fl_orph_ov", out_valid, 32'd0);
    end
    step(); data_ok = 1'b1; cache_data = 32'h55; #1;
    chk("fl_new_fv", fwd_valid, 32'd1);
    chk("fl_new_fd", fwd_wdata, 32'h55);
    step(); out_ready = 1'b1; #1;
    chk("fl_new_ov", out_valid, 32'd1);
    chk("fl_new_od", out_wdata, 32'h55);
    chk("fl_new_oa", out_waddr, 32'd12);

    // Flush and data_ok together with 2 pending: exactly one orphan.
    step(); push(5'd13, 3'd2, 2'd0); #1;
    step(); push(5'd14, 3'd2, 2'd0); #1;
    step(); flush = 1'b1; data_ok = 1'b1; cache_data = 32'h99; #1;
    step(); push(5'd15, 3'd2, 2'd0); #1;
    step(); data_ok = 1'b1; cache_data = 32'h66; #1;
    chk("fd_orph_fv", fwd_valid, 32'd0);
    chk("fd_orph_fw", fwd_wreg, 32'd1);
    step(); data_ok = 1'b1; cache_data = 32'h77; #1;
    chk("fd_new_fv", fwd_valid, 32'd1);
    chk("fd_new_fd", fwd_wdata, 32'h77);
    step(); out_ready = 1'b1; #1;
    chk("fd_new_od", out_wdata, 32'h77);
    chk("fd_new_oa", out_waddr, 32'd15);

    // Head response with out_ready already high.
    step(); push(5'd16, 3'd2, 2'd0); #1;
    step(); data_ok = 1'b1; cache_data = 32'h1234; out_ready = 1'b1; #1;
`ifdef MEM2_LOAD_BYPASS_EN
    chk("byp_ov", out_valid, 32'd1);
    chk("byp_od", out_wdata, 32'h1234);
    step(); #1;
    chk("byp_after_ov", out_valid, 32'd0);
    chk("byp_after_fw", fwd_wreg, 32'd0);
`else
    chk("byp_ov", out_valid, 32'd0);
    step(); out_ready = 1'b1; #1;
    chk("nobyp_ov", out_valid, 32'd1);
    chk("nobyp_od", out_wdata, 32'h1234);
    step(); #1;
    chk("nobyp_after_ov", out_valid, 32'd0);
`endif

    // Reset mid-operation clears the orphan counter too.
    step(); push(5'd17, 3'd2, 2'd0); #1;
    step(); push(5'd18, 3'd2, 2'd0); #1;
    step(); flush = 1'b1; #1;
    step(); rst = 1'b1; #1;
    step(); rst = 1'b0; push(5'd19, 3'd2, 2'd0); #1;
    chk("mrst_ir", in_ready, 32'd1);
    chk("mrst_ov", out_valid, 32'd0);
    step(); data_ok = 1'b1; cache_data = 32'hAB; #1;
    chk("mrst_fv", fwd_valid, 32'd1);
    chk("mrst_fd", fwd_wdata, 32'hAB);
    step(); out_ready = 1'b1; #1;
    chk("mrst_od", out_wdata, 32'hAB);
    step(); #1;
    chk("mrst_empty_ov", out_valid, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
